// File: rtl/case2_pkg.sv
// Shared definitions for the case-2 result path: default dimensions, index widths,
// result RAM address mapping and the reader FSM states.
package case2_pkg;

    localparam int J_DEF = 14;
    localparam int I_DEF = 7;
    localparam int A_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Index fields carry one spare bit so the full range count itself is representable.
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int result_addr(input int a, input int j, input int i,
                                       input int jd, input int id);
        return (a * jd + j) * id + i;
    endfunction

endpackage

// File: rtl/case2_skid_fifo2.sv
// Two-entry fall-through FIFO: when empty the input beat is presented combinationally (0 cycles).
// Head is held stable while out_ready is low; upstream must never push into a full FIFO without a pop.
module case2_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         empty;
    logic         push;
    logic         pop;

    assign empty     = (count == 2'd0);
    assign out_valid = !empty || in_valid;
    assign out_data  = !empty ? mem[rd_ptr] : (in_valid ? in_data : '0);

    // A beat that bypasses straight to an accepting consumer is never stored.
    assign push = in_valid && !(empty && out_ready);
    assign pop  = !empty && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/case2_result_reader.sv
// Streams the result RAM out in ascending (a, j, i) order after done_in; beat 0 valid 2 cycles after done_in.
// Reads are throttled so the 2-entry FIFO can always absorb returning data under any out_ready pattern.
module case2_result_reader
    import case2_pkg::*;
#(
    parameter int  J       = J_DEF,
    parameter int  I       = I_DEF,
    parameter int  A       = A_DEF,
    parameter int  DATA_W  = 16,
    localparam int J_WIDTH = idx_width(J),
    localparam int I_WIDTH = idx_width(I),
    localparam int A_WIDTH = idx_width(A),
    localparam int N       = J * I * A,
    localparam int ADDR_W  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done_in,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [A_WIDTH-1:0] out_a,
    output logic [J_WIDTH-1:0] out_j,
    output logic [I_WIDTH-1:0] out_i,
    output logic               out_last,
    output logic               busy,
    output logic               err
);

    localparam int PW = DATA_W + A_WIDTH + J_WIDTH + I_WIDTH + 1;

    state_e             state;
    logic [A_WIDTH-1:0] cnt_a, nxt_a, ret_a;
    logic [J_WIDTH-1:0] cnt_j, nxt_j, ret_j;
    logic [I_WIDTH-1:0] cnt_i, nxt_i, ret_i;
    logic               ret_vld;
    logic               ret_last;
    logic [1:0]         fifo_count;
    logic [2:0]         occ;
    logic               pop;
    logic               issue;
    logic               rd_last;
    logic [ADDR_W-1:0]  nxt_addr;
    logic [PW-1:0]      in_payload;
    logic [PW-1:0]      out_payload;

    assign pop     = out_valid && out_ready;
    assign rd_last = (rd_addr == ADDR_W'(N - 1));
    assign busy    = (state != ST_IDLE);

    // Reads still owed a FIFO slot: stored beats, the word returning now and the read on the bus.
    // A beat leaving this cycle frees one slot, so steady state sustains one read per cycle.
    assign occ   = 3'(fifo_count) + 3'(ret_vld) + 3'(rd_en);
    assign issue = (state == ST_READ) && (occ < (pop ? 3'd3 : 3'd2));

    always_comb begin
        nxt_a = cnt_a;
        nxt_j = cnt_j;
        nxt_i = cnt_i + 1'b1;
        if (cnt_i == I_WIDTH'(I - 1)) begin
            nxt_i = '0;
            nxt_j = cnt_j + 1'b1;
            if (cnt_j == J_WIDTH'(J - 1)) begin
                nxt_j = '0;
                nxt_a = cnt_a + 1'b1;
            end
        end
    end

    assign nxt_addr = ADDR_W'(result_addr(int'(nxt_a), int'(nxt_j), int'(nxt_i), J, I));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt_a    <= '0;
            cnt_j    <= '0;
            cnt_i    <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            ret_vld  <= 1'b0;
            ret_a    <= '0;
            ret_j    <= '0;
            ret_i    <= '0;
            ret_last <= 1'b0;
            err      <= 1'b0;
        end else begin
            ret_vld  <= rd_en;
            ret_a    <= cnt_a;
            ret_j    <= cnt_j;
            ret_i    <= cnt_i;
            ret_last <= rd_en && rd_last;
            rd_en    <= 1'b0;

            if (done_in && (state != ST_IDLE)) err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (done_in) begin
                        state   <= ST_READ;
                        cnt_a   <= '0;
                        cnt_j   <= '0;
                        cnt_i   <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        cnt_a   <= nxt_a;
                        cnt_j   <= nxt_j;
                        cnt_i   <= nxt_i;
                        rd_addr <= nxt_addr;
                        rd_en   <= 1'b1;
                        if (nxt_addr == ADDR_W'(N - 1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_payload = {rd_data, ret_a, ret_j, ret_i, ret_last};

    case2_skid_fifo2 #(
        .W(PW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ret_vld),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .count     (fifo_count)
    );

    assign {out_data, out_a, out_j, out_i, out_last} = out_payload;

endmodule

// File: tb/tb_case2_result_reader.sv
// Scoreboard bench for case2_result_reader: expected beats are queued on done_in and
// compared on every accepted beat; stalls, throttling, errors and resets are checked alongside.
module tb_case2_result_reader;

    localparam int J = 14;
    localparam int I = 7;
    localparam int A = 2;
    localparam int N = J * I * A;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_a;
    logic [4:0]  out_j;
    logic [3:0]  out_i;
    logic        out_last;
    logic        busy;
    logic        err;

    logic [15:0] mem [256];
    logic [31:0] sb [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issued = 0;
    int accepted = 0;
    int max_os = 0;
    int last_acc_cyc = 0;
    int rdy_mode = 0;
    int t_cyc = 0;
    bit stalled = 0;
    logic [31:0] held = '0;

    case2_result_reader dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_a     (out_a),
        .out_j     (out_j),
        .out_i     (out_i),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_beat(input int k);
        logic [15:0] d;
        logic [1:0]  a;
        logic [4:0]  j;
        logic [3:0]  i;
        d = 16'(k * 3);
        a = 2'(k / (J * I));
        j = 5'((k / I) % J);
        i = 4'(k % I);
        return {4'b0, d, a, j, i, (k == N - 1)};
    endfunction

    function automatic logic [31:0] snap();
        return {3'b0, out_valid, out_data, out_a, out_j, out_i, out_last};
    endfunction

    // Monitor: scoreboard compare, stall stability and read-throttle tracking.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            issued   = 0;
            accepted = 0;
            max_os   = 0;
            stalled  = 0;
        end else begin
            if (rd_en) begin
                if (issued - accepted > max_os) max_os = issued - accepted;
                issued++;
            end
            if (stalled) check("hold", snap(), held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {4'b0, out_data, out_a, out_j, out_i, out_last}, 32'hFFFF_FFFF);
                end else begin
                    check("beat", {4'b0, out_data, out_a, out_j, out_i, out_last}, sb.pop_front());
                end
                accepted++;
                if (out_last) last_acc_cyc = cyc;
            end
            stalled = out_valid && !out_ready;
            held    = snap();
        end
    end

    task automatic drive_ready();
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 99) < 40);
        else                    out_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        done_in = 1'b0;
        drive_ready();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        done_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sample();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"},     32'(rd_en),     32'd0);
        check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_idx"},   32'({out_a, out_j, out_i}), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
    endtask

    task automatic start_run();
        @(posedge clk);
        #1;
        drive_ready();
        for (int k = 0; k < N; k++) sb.push_back(exp_beat(k));
        done_in = 1'b1;
        sample();
        t_cyc = cyc;
        tick();
        sample();
        check("t1_busy",      32'(busy),      32'd1);
        check("t1_rd_en",     32'(rd_en),     32'd1);
        check("t1_rd_addr",   32'(rd_addr),   32'd0);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        tick();
        sample();
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_beat0", {4'b0, out_data, out_a, out_j, out_i, out_last}, exp_beat(0));
    endtask

    task automatic wait_stream(input int target, input int pulse_at, input bit stall_last);
        int  n = 0;
        int  stall_cnt = 0;
        bit  pulsed = 0;
        while (accepted < target && n < 4000) begin
            tick();
            if (pulse_at >= 0 && !pulsed && accepted >= pulse_at) begin
                done_in = 1'b1;
                pulsed  = 1'b1;
            end
            if (stall_last && out_valid && out_last && stall_cnt < 10) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            sample();
            n++;
            if (stall_last && !out_ready && out_last)
                check("stall_last", 32'({busy, out_last, out_valid}), 32'b111);
        end
        check("accepted", 32'(accepted), 32'(target));
    endtask

    initial begin
        rst       = 1'b1;
        done_in   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 256; k++) mem[k] = 16'(k * 3);

        // Reset state and no activity while idle
        do_reset();
        check_reset_values("rst");
        repeat (5) begin
            tick();
            sample();
        end
        check("idle_no_reads", 32'(issued), 32'd0);

        // Full run, out_ready held high
        rdy_mode = 0;
        start_run();
        wait_stream(N, -1, 1'b0);
        check("last_beat_time", 32'(last_acc_cyc - t_cyc), 32'(N + 1));
        check("busy_at_last", 32'(busy), 32'd1);
        tick();
        sample();
        check("busy_after_last", 32'(busy), 32'd0);
        check("full_outstanding", 32'(max_os <= 1), 32'd1);
        check("full_err", 32'(err), 32'd0);

        // Random backpressure
        do_reset();
        rdy_mode = 1;
        start_run();
        wait_stream(N, -1, 1'b0);
        check("bp_outstanding", 32'(max_os <= 1), 32'd1);
        rdy_mode = 0;
        tick();
        sample();
        check("bp_busy_done", 32'(busy), 32'd0);

        // done_in during a run: sticky error, no restart
        do_reset();
        start_run();
        wait_stream(N, 50, 1'b0);
        check("err_set", 32'(err), 32'd1);
        repeat (10) begin
            tick();
            sample();
        end
        check("no_restart_reads", 32'(issued), 32'(N));
        check("no_restart_valid", 32'({busy, out_valid}), 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        // Reset mid-stream, then a fresh run from address 0
        do_reset();
        start_run();
        wait_stream(100, -1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample();
        check_reset_values("mid");
        start_run();
        wait_stream(N, -1, 1'b0);

        // Stall with the final beat presented
        do_reset();
        start_run();
        wait_stream(N, -1, 1'b1);
        tick();
        sample();
        check("stall_busy_release", 32'(busy), 32'd0);
        check("stall_outstanding", 32'(max_os <= 1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
